// File: rtl/rom_addr_ctrl_if.sv
// rom_addr_ctrl_if: key-flag / ROM-address bundle between the key filters,
// the address sequencer and the ROM.
//   key1_flag, key2_flag : one-cycle debounced press pulses
//   addr                 : registered ROM read address
//   hold                 : high while a preset address is frozen on addr
// master = key/stimulus side, slave = rom_addr_ctrl.
interface rom_addr_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              key1_flag;
    logic              key2_flag;
    logic [ADDR_W-1:0] addr;
    logic              hold;

    modport master (
        output key1_flag,
        output key2_flag,
        input  addr,
        input  hold
    );

    modport slave (
        input  key1_flag,
        input  key2_flag,
        output addr,
        output hold
    );
endinterface

// File: rtl/rom_addr_ctrl.sv
// rom_addr_ctrl: ROM address sequencer for the ROM display experiment.
// In RUN the address steps every CNT_MAX+1 cycles and wraps after ADDR_MAX.
// A key1/key2 press freezes addr on KEY1_ADDR/KEY2_ADDR; pressing the same
// key again resumes from the frozen position, pressing the other key
// switches directly between presets. key1 wins when both keys pulse together.
// Ports:
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   ctrl_bus  : key flags in, registered addr/hold out (slave modport)
// ctrl_bus must be instantiated with the same ADDR_W as this module.
module rom_addr_ctrl #(
    parameter int unsigned CNT_MAX   = 9_999_999,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned ADDR_MAX  = 255,
    parameter int unsigned KEY1_ADDR = 99,
    parameter int unsigned KEY2_ADDR = 199
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    rom_addr_ctrl_if.slave  ctrl_bus
);
    localparam int unsigned CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(CNT_MAX);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(ADDR_MAX);
    localparam logic [ADDR_W-1:0] K1_ADDR  = ADDR_W'(KEY1_ADDR);
    localparam logic [ADDR_W-1:0] K2_ADDR  = ADDR_W'(KEY2_ADDR);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD1 = 2'd1,
        HOLD2 = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0] run_addr, run_addr_next;
    logic [ADDR_W-1:0] addr_next;
    logic              hold_next;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= RUN;
            cnt           <= '0;
            run_addr      <= '0;
            ctrl_bus.addr <= '0;
            ctrl_bus.hold <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            run_addr      <= run_addr_next;
            ctrl_bus.addr <= addr_next;
            ctrl_bus.hold <= hold_next;
        end
    end

    // addr/hold are decoded from the current state, so they trail both the
    // step edge and any state change by one cycle and never see the flags
    // combinationally.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        run_addr_next = run_addr;
        addr_next     = run_addr;
        hold_next     = 1'b0;

        unique case (state)
            RUN: begin
                addr_next = run_addr;
                hold_next = 1'b0;
                // A press on the terminal-count cycle suppresses the step.
                if (ctrl_bus.key1_flag) begin
                    state_next = HOLD1;
                    cnt_next   = '0;
                end else if (ctrl_bus.key2_flag) begin
                    state_next = HOLD2;
                    cnt_next   = '0;
                end else if (cnt == CNT_TOP) begin
                    cnt_next      = '0;
                    run_addr_next = (run_addr == ADDR_TOP) ? '0 : run_addr + 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HOLD1: begin
                addr_next = K1_ADDR;
                hold_next = 1'b1;
                cnt_next  = '0;
                if (ctrl_bus.key1_flag) begin
                    state_next = RUN;
                end else if (ctrl_bus.key2_flag) begin
                    state_next = HOLD2;
                end
            end
            HOLD2: begin
                addr_next = K2_ADDR;
                hold_next = 1'b1;
                cnt_next  = '0;
                if (ctrl_bus.key1_flag) begin
                    state_next = HOLD1;
                end else if (ctrl_bus.key2_flag) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end
endmodule

// File: doc/rom_addr_ctrl.md
Name: rom_addr_ctrl

Overview:
- Address sequencer that sits directly upstream of the 256x8 ROM in the ROM display experiment.
- Consumes the single-cycle press flags from the two key_filter instances and produces the ROM read address.
- Free-running mode steps the address every 200 ms; a key press freezes the output on a fixed preset address until the same key is pressed again.
- The ROM data it selects feeds the seg_595 display path.

Parameters:
- CNT_MAX, 9_999_999, step-timer terminal count; period = CNT_MAX+1 cycles (200 ms at 50 MHz).
- ADDR_W, 8, address width.
- ADDR_MAX, 255, last address before wrap to 0; must be <= 2^ADDR_W-1.
- KEY1_ADDR, 99, address shown while in HOLD1.
- KEY2_ADDR, 199, address shown while in HOLD2.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous, active-low reset.
- key1_flag  input  1  one-cycle pulse per debounced key1 press.
- key2_flag  input  1  one-cycle pulse per debounced key2 press.
- addr  output  ADDR_W  registered ROM read address.
- hold  output  1  high while in HOLD1 or HOLD2; registered.

Behaviour:
- Reset (async assert, sync release):
  - state = RUN, cnt = 0, run_addr = 0, addr = 0, hold = 0.
- Internal registers:
  - cnt: width ceil(log2(CNT_MAX+1)).
  - run_addr: ADDR_W bits; holds the free-running position.
- State RUN:
  - cnt increments each cycle; at cnt==CNT_MAX, cnt goes to 0 and run_addr goes to run_addr+1.
  - Wrap: run_addr==ADDR_MAX steps to 0.
  - addr follows run_addr with one cycle of latency; addr changes on the cycle after the step edge.
- State HOLD1 / HOLD2:
  - cnt is held at 0 and run_addr is frozen.
  - addr = KEY1_ADDR / KEY2_ADDR, registered, valid on the cycle after entry.
  - hold = 1.
- Transitions, evaluated on the clock edge where a flag is high:
  - RUN + key1_flag -> HOLD1.
  - RUN + key2_flag -> HOLD2.
  - HOLD1 + key1_flag -> RUN.
  - HOLD1 + key2_flag -> HOLD2 (direct switch).
  - HOLD2 + key2_flag -> RUN.
  - HOLD2 + key1_flag -> HOLD1.
- Simultaneous key1_flag and key2_flag: key1 has priority; key2 is ignored that cycle.
- Resume to RUN:
  - cnt restarts at 0 and addr returns to the frozen run_addr.
  - The next step occurs CNT_MAX+1 cycles after resume.
- Flag coincident with cnt==CNT_MAX in RUN:
  - The transition wins; run_addr does not increment and cnt clears.
- Flags wider than one cycle are not legal input. Each high cycle counts as a press.
- Reset asserted mid-hold or mid-count: everything returns to reset values immediately, with no glitch dependence on the clock.
- No combinational path from the flags to addr.

Test Plan (bench overrides CNT_MAX=9; period = 10 cycles):
1. Release reset, no keys -> addr = 0 for 10 cycles, then 1, 2, 3 at 10-cycle spacing; hold = 0 throughout.
2. Run to addr 255, wait 10 cycles -> addr = 0 (wrap); no intermediate value.
3. Pulse key1_flag while addr = 5:
   - Next cycle: addr = 99, hold = 1; it stays 99 for 50+ cycles.
   - Pulse key1_flag again: next cycle addr = 5; addr = 6 exactly 10 cycles later.
4. From RUN at addr 7:
   - Pulse key2_flag: addr = 199.
   - Pulse key1_flag: addr = 99.
   - Pulse key1_flag: addr = 7, hold = 0.
5. Pulse key1_flag and key2_flag on the same cycle in RUN -> addr = 99, state HOLD1. A key2 pulse then gives addr = 199.
6. Assert sys_rst_n = 0 mid-cycle while in HOLD2 -> addr = 0, hold = 0 within the same cycle. After release, addr = 1 at 10 cycles.
